// File: rtl/aes_text_out_streamer.sv
// AES result streamer: captures text_out on done and emits it
// MS word first over valid/ready, with one pending block of slack.
module aes_text_out_streamer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [127:0]      text_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int BLK_W  = 128;
  localparam int NWORDS = BLK_W / WORD_W;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  logic [BLK_W-1:0] r_act_q;
  logic [BLK_W-1:0] r_pnd_q;
  logic             r_act_full;
  logic             r_pnd_full;
  logic [IW-1:0]    r_idx;
  logic             r_ovf;

  logic             w_xfer;
  logic             w_free;
  logic             w_act_avail;
  logic             w_drop;
  logic [BLK_W-1:0] w_sh;

  assign w_xfer      = r_act_full && m_ready;
  assign w_free      = w_xfer && (r_idx == LAST);
  assign w_act_avail = !r_act_full || w_free;
  assign w_drop      = done && !w_act_avail && r_pnd_full;

  // Word 0 sits in the top bits, so shift the selected word up
  assign w_sh = r_act_q << (int'(r_idx) * WORD_W);

  assign m_valid  = r_act_full;
  assign m_data   = w_sh[BLK_W-1 -: WORD_W];
  assign m_last   = r_act_full && (r_idx == LAST);
  assign busy     = r_act_full || r_pnd_full;
  assign overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_q    <= '0;
      r_pnd_q    <= '0;
      r_act_full <= 1'b0;
      r_pnd_full <= 1'b0;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_idx <= w_free ? '0 : r_idx + IW'(1);
      end

      if (w_act_avail) begin
        if (r_pnd_full) begin
          r_act_q    <= r_pnd_q;
          r_act_full <= 1'b1;
          if (done) begin
            r_pnd_q <= text_out;
          end else begin
            r_pnd_full <= 1'b0;
          end
        end else if (done) begin
          r_act_q    <= text_out;
          r_act_full <= 1'b1;
        end else if (w_free) begin
          r_act_full <= 1'b0;
        end
      end else if (done && !r_pnd_full) begin
        r_pnd_q    <= text_out;
        r_pnd_full <= 1'b1;
      end

      // A new drop outranks a same-cycle clear
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_text_out_streamer.sv
// Directed bench for aes_text_out_streamer with an
// in-order word scoreboard checked at every transfer.
module tb_aes_text_out_streamer;

  localparam int W  = 32;
  localparam int NW = 128 / W;

  logic          clk = 1'b0;
  logic          rst;
  logic          done;
  logic [127:0]  text_out;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          overflow;
  logic          ovf_clr;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int x0;

  logic [W:0] q[$];

  aes_text_out_streamer #(.WORD_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .text_out (text_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_blk(input logic [127:0] b);
    for (int i = 0; i < NW; i++) begin
      q.push_back({(i == NW - 1), b[127 - W*i -: W]});
    end
  endtask

  task automatic pulse(input logic [127:0] b);
    done     = 1'b1;
    text_out = b;
    tick();
    done     = 1'b0;
    text_out = 'x;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (q.size() != 0 || busy); i++) begin
      tick();
    end
    chk({tag, "_qempty"}, 128'(q.size()), 128'd0);
    chk({tag, "_idle"}, 128'(busy), 128'd0);
  endtask

  // Scoreboard monitor plus AXI-style hold check
  initial begin
    logic         stall;
    logic [W-1:0] pd;
    logic         pl;
    logic [W:0]   e;
    stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 128'(m_valid), 128'd1);
          chk("hold_data", 128'(m_data), 128'(pd));
          chk("hold_last", 128'(m_last), 128'(pl));
        end
        if (m_valid && m_ready) begin
          xfers++;
          if (q.size() == 0) begin
            chk("unexpected_word", 128'(m_data), 128'hx);
          end else begin
            e = q.pop_front();
            chk("word_data", 128'(m_data), 128'(e[W-1:0]));
            chk("word_last", 128'(m_last), 128'(e[W]));
          end
        end
        stall = m_valid && !m_ready;
        pd = m_data;
        pl = m_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, c, d;
    rst = 1'b1;
    done = 1'b0;
    text_out = '0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_valid", 128'(m_valid), 128'd0);
    chk("rst_last", 128'(m_last), 128'd0);
    chk("rst_data", 128'(m_data), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    rst = 1'b0;
    tick();

    // Single block, continuous ready
    a = 128'h3925841D_02DC09FB_DC118597_196A0B32;
    m_ready = 1'b1;
    push_blk(a);
    x0 = xfers;
    pulse(a);
    chk("single_lat_valid", 128'(m_valid), 128'd1);
    chk("single_w0", 128'(m_data), 128'h3925841D);
    for (int i = 0; i < NW; i++) tick();
    chk("single_idle", 128'(busy), 128'd0);
    chk("single_cnt", 128'(xfers - x0), 128'd4);

    // Backpressure pattern
    begin
      logic [6:0] pat;
      pat = 7'b1100101;
      m_ready = 1'b0;
      push_blk(a);
      x0 = xfers;
      pulse(a);
      for (int i = 6; i >= 0; i--) begin
        m_ready = pat[i];
        tick();
      end
      chk("bp_cnt", 128'(xfers - x0), 128'd4);
      chk("bp_idle", 128'(busy), 128'd0);
    end

    // Back-to-back completions, no gap
    a = '0;
    b = '1;
    m_ready = 1'b1;
    push_blk(a);
    push_blk(b);
    x0 = xfers;
    pulse(a);
    chk("b2b_valid_first", 128'(m_valid), 128'd1);
    pulse(b);
    for (int i = 0; i < 7; i++) begin
      chk("b2b_no_gap", 128'(m_valid), 128'd1);
      tick();
    end
    chk("b2b_idle", 128'(busy), 128'd0);
    chk("b2b_cnt", 128'(xfers - x0), 128'd8);
    chk("b2b_ovf", 128'(overflow), 128'd0);

    // Overflow: third completion dropped
    a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    b = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    c = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    m_ready = 1'b0;
    push_blk(a);
    push_blk(b);
    pulse(a);
    pulse(b);
    pulse(c);
    chk("ovf_set", 128'(overflow), 128'd1);
    chk("ovf_busy", 128'(busy), 128'd1);
    chk("ovf_head", 128'(m_data), 128'h00112233);
    m_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", 128'(overflow), 128'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 128'(overflow), 128'd0);

    // Set wins over same-cycle clear
    m_ready = 1'b0;
    push_blk(a);
    push_blk(b);
    pulse(a);
    pulse(b);
    ovf_clr = 1'b1;
    pulse(c);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 128'(overflow), 128'd1);
    m_ready = 1'b1;
    drain("sw_drain");
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sw_clr", 128'(overflow), 128'd0);

    // done lands on the cycle A's last word is taken
    m_ready = 1'b0;
    push_blk(a);
    push_blk(b);
    push_blk(c);
    pulse(a);
    pulse(b);
    m_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("sim_last_pending", 128'(m_last), 128'd1);
    pulse(c);
    chk("sim_ovf", 128'(overflow), 128'd0);
    chk("sim_busy", 128'(busy), 128'd1);
    chk("sim_b_head", 128'(m_data), 128'hA5A5A5A5);
    drain("sim_drain");

    // Reset mid-block with pending full
    d = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    m_ready = 1'b0;
    q.push_back({1'b0, a[127:96]});
    q.push_back({1'b0, a[95:64]});
    pulse(a);
    pulse(b);
    m_ready = 1'b1;
    tick();
    tick();
    m_ready = 1'b0;
    rst = 1'b1;
    done = 1'b1;
    text_out = c;
    tick();
    rst = 1'b0;
    done = 1'b0;
    text_out = 'x;
    chk("mrst_valid", 128'(m_valid), 128'd0);
    chk("mrst_busy", 128'(busy), 128'd0);
    chk("mrst_ovf", 128'(overflow), 128'd0);
    chk("mrst_q", 128'(q.size()), 128'd0);
    tick();
    chk("mrst_done_ignored", 128'(m_valid), 128'd0);
    push_blk(d);
    pulse(d);
    chk("mrst_fresh_w0", 128'(m_data), 128'h01020304);
    m_ready = 1'b1;
    drain("mrst_drain");

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
